// File: rtl/instr_sequencer.sv
// Fetch/execute controller: fetches 16-bit instructions as two bytes and sequences
// loads, stores and flag-conditional jumps for the accumulator datapath.
module instr_sequencer #(
    parameter logic [9:0] RESET_PC = 10'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iStart,
    input  logic [7:0]  iReadData,
    input  logic        iZa,
    input  logic        iZb,
    input  logic        iCa,
    input  logic        iCb,
    input  logic        iNa,
    input  logic        iNb,
    output logic        oRead,
    output logic [9:0]  oReadAddress,
    output logic        oWriteEnable,
    output logic [9:0]  oAddress,
    output logic        oWriteSel,
    output logic        oReadToA,
    output logic        oReadToB,
    output logic [15:0] oInstruction,
    output logic [9:0]  oPC,
    output logic        oHalted,
    output logic        oIllegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_HI, S_FETCH_LO, S_LATCH, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_pc;
    logic [15:0] r_ir;
    logic [7:0]  r_ir_hi;

    logic [3:0]  w_op;
    logic [9:0]  w_addr;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_illegal;
    logic        w_taken;

    assign w_op         = r_ir[15:12];
    assign w_addr       = r_ir[9:0];
    assign w_is_load    = (w_op == 4'h1) || (w_op == 4'h2);
    assign w_is_store   = (w_op == 4'h3) || (w_op == 4'h4);
    assign w_is_illegal = (w_op == 4'hC) || (w_op == 4'hD) || (w_op == 4'hE);

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            4'h5:    w_taken = 1'b1;
            4'h6:    w_taken = iZa;
            4'h7:    w_taken = iZb;
            4'h8:    w_taken = iCa;
            4'h9:    w_taken = iCb;
            4'hA:    w_taken = iNa;
            4'hB:    w_taken = iNb;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (iStart) w_next = S_FETCH_HI;
            S_FETCH_HI: w_next = S_FETCH_LO;
            S_FETCH_LO: w_next = S_LATCH;
            S_LATCH:    w_next = S_EXEC;
            S_EXEC: begin
                if (w_is_load)          w_next = S_WB;
                else if (w_op == 4'hF)  w_next = S_HALT;
                else                    w_next = S_FETCH_HI;
            end
            S_WB:       w_next = S_FETCH_HI;
            S_HALT:     if (iStart) w_next = S_FETCH_HI;
            default:    w_next = S_IDLE;
        endcase
    end

    // High byte is staged so the decoder sees a whole new instruction only after LATCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_ir_hi <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: if (iStart) r_pc <= RESET_PC;
                S_FETCH_LO:     r_ir_hi <= iReadData;
                S_LATCH: begin
                    r_ir <= {r_ir_hi, iReadData};
                    r_pc <= r_pc + 10'd2;
                end
                S_EXEC:         if (w_taken) r_pc <= w_addr;
                default: ;
            endcase
        end
    end

    always_comb begin
        oRead        = 1'b0;
        oReadAddress = '0;
        oWriteEnable = 1'b0;
        oAddress     = '0;
        oWriteSel    = 1'b0;
        oReadToA     = 1'b0;
        oReadToB     = 1'b0;
        oHalted      = 1'b0;
        oIllegal     = 1'b0;
        case (r_state)
            S_FETCH_HI: begin
                oRead        = 1'b1;
                oReadAddress = r_pc;
            end
            S_FETCH_LO: begin
                oRead        = 1'b1;
                oReadAddress = r_pc + 10'd1;
            end
            S_EXEC: begin
                if (w_is_load) begin
                    oRead        = 1'b1;
                    oReadAddress = w_addr;
                end
                if (w_is_store) begin
                    oWriteEnable = 1'b1;
                    oAddress     = w_addr;
                    oWriteSel    = (w_op == 4'h4);
                end
                oIllegal = w_is_illegal;
            end
            S_WB: begin
                oReadAddress = w_addr;
                oReadToA     = (w_op == 4'h1);
                oReadToB     = (w_op == 4'h2);
            end
            S_HALT:  oHalted = 1'b1;
            default: ;
        endcase
    end

    assign oInstruction = r_ir;
    assign oPC          = r_pc;

endmodule
